// File: rtl/prbs15_pkg.sv
// Shared definitions for the PRBS-15 pattern generator: FSM/phase encoding,
// polynomial tap positions and a single-step LFSR helper.
package prbs15_pkg;

   localparam int LFSR_W      = 15;
   localparam int POLY_TAP_HI = 14;
   localparam int POLY_TAP_LO = 13;

   // State encoding doubles as the externally visible phase code.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      REPEAT = 2'd2,
      PRBS   = 2'd3
   } state_t;

   // One Fibonacci step of x^15+x^14+1: feedback bit enters at the LSB.
   function automatic logic [LFSR_W-1:0] lfsr_adv1(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], s[POLY_TAP_HI] ^ s[POLY_TAP_LO]};
   endfunction

endpackage

// File: rtl/prbs15_pattern_gen_if.sv
// Control/data bundle between the pattern generator and its user.
interface prbs15_pattern_gen_if #(
   parameter int DATA_W = 8,
   parameter int REP_W  = 2
) ();

   logic              start;
   logic              stop;
   logic [REP_W-1:0]  n;
   logic [DATA_W-1:0] data_in;
   logic              data_in_valid;
   logic [DATA_W-1:0] data_out;
   logic              data_out_valid;
   logic              busy;
   logic [1:0]        phase;

   // Pattern consumer / sequencer side
   modport master (
      output start, stop, n, data_in, data_in_valid,
      input  data_out, data_out_valid, busy, phase
   );

   // Pattern generator side
   modport slave (
      input  start, stop, n, data_in, data_in_valid,
      output data_out, data_out_valid, busy, phase
   );

endinterface

// File: rtl/prbs15_step.sv
// Combinational multi-step PRBS-15 advance: produces DATA_W new bits
// (first-generated bit in the MSB) and the resulting LFSR state.
module prbs15_step
   import prbs15_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [LFSR_W-1:0] s_in,
   output logic [LFSR_W-1:0] s_out,
   output logic [DATA_W-1:0] bits
);

   logic [LFSR_W-1:0] s_work;

   // Unroll DATA_W single steps, collecting each feedback bit MSB-first.
   always_comb begin
      s_work = s_in;
      bits   = '0;
      for (int i = 0; i < DATA_W; i++) begin
         s_work                = lfsr_adv1(s_work);
         bits[DATA_W - 1 - i]  = s_work[0];
      end
      s_out = s_work;
   end

endmodule

// File: rtl/prbs15_pattern_gen.sv
// Test-pattern source: captures a NUM_WORDS preamble, replays it n times,
// then streams PRBS-15 words until stopped.
module prbs15_pattern_gen
   import prbs15_pkg::*;
#(
   parameter int               DATA_W    = 8,
   parameter int               NUM_WORDS = 4,
   parameter int               REP_W     = 2,
   parameter logic [LFSR_W-1:0] SEED     = 15'h7FFF
) (
   input logic                clk,
   input logic                rst,
   prbs15_pattern_gen_if.slave bus
);

   localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int CNT_W = REP_W + $clog2(NUM_WORDS) + 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);

   state_t             state;
   logic [REP_W-1:0]   n_lat;
   logic [IDX_W-1:0]   idx;
   logic [CNT_W-1:0]   rep_cnt;
   logic [DATA_W-1:0]  pre_buf [NUM_WORDS];
   logic [LFSR_W-1:0]  lfsr;
   logic [LFSR_W-1:0]  lfsr_next;
   logic [DATA_W-1:0]  prbs_bits;
   logic [DATA_W-1:0]  data_out_r;
   logic               valid_r;
   logic               busy_r;
   logic [1:0]         phase_r;

   prbs15_step #(.DATA_W(DATA_W)) u_step (
      .s_in  (lfsr),
      .s_out (lfsr_next),
      .bits  (prbs_bits)
   );

   assign bus.data_out       = data_out_r;
   assign bus.data_out_valid = valid_r;
   assign bus.busy           = busy_r;
   assign bus.phase          = phase_r;

   // Sequencer FSM with its counters, preamble store and registered outputs.
   // phase/busy are updated on every transition so they always match state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         n_lat      <= '0;
         idx        <= '0;
         rep_cnt    <= '0;
         lfsr       <= SEED;
         data_out_r <= '0;
         valid_r    <= 1'b0;
         busy_r     <= 1'b0;
         phase_r    <= IDLE;
         for (int i = 0; i < NUM_WORDS; i++) begin
            pre_buf[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               valid_r <= 1'b0;
               if (bus.start && !bus.stop) begin
                  n_lat   <= bus.n;
                  idx     <= '0;
                  state   <= LOAD;
                  phase_r <= LOAD;
                  busy_r  <= 1'b1;
               end
            end
            LOAD: begin
               valid_r <= 1'b0;
               if (bus.stop) begin
                  idx     <= '0;
                  state   <= IDLE;
                  phase_r <= IDLE;
                  busy_r  <= 1'b0;
               end else if (bus.data_in_valid) begin
                  pre_buf[idx] <= bus.data_in;
                  if (idx == IDX_LAST) begin
                     idx <= '0;
                     if (n_lat != '0) begin
                        rep_cnt <= CNT_W'(n_lat) * CNT_W'(NUM_WORDS) - CNT_W'(1);
                        state   <= REPEAT;
                        phase_r <= REPEAT;
                     end else begin
                        lfsr    <= SEED;
                        state   <= PRBS;
                        phase_r <= PRBS;
                     end
                  end else begin
                     idx <= idx + IDX_W'(1);
                  end
               end
            end
            REPEAT: begin
               if (bus.stop) begin
                  valid_r <= 1'b0;
                  idx     <= '0;
                  state   <= IDLE;
                  phase_r <= IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  data_out_r <= pre_buf[idx];
                  valid_r    <= 1'b1;
                  idx        <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
                  if (rep_cnt == '0) begin
                     lfsr    <= SEED;
                     state   <= PRBS;
                     phase_r <= PRBS;
                  end else begin
                     rep_cnt <= rep_cnt - CNT_W'(1);
                  end
               end
            end
            PRBS: begin
               if (bus.stop) begin
                  valid_r <= 1'b0;
                  idx     <= '0;
                  state   <= IDLE;
                  phase_r <= IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  data_out_r <= prbs_bits;
                  valid_r    <= 1'b1;
                  lfsr       <= lfsr_next;
               end
            end
            default: begin
               valid_r <= 1'b0;
               state   <= IDLE;
               phase_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prbs15_pattern_gen.sv
// Self-checking bench for prbs15_pattern_gen (DATA_W=8, NUM_WORDS=4, REP_W=2).
// Reference: PRBS bit sequence from the recurrence b[t] = b[t-15] ^ b[t-14]
// seeded with fifteen ones, packed MSB-first into bytes.
module tb_prbs15_pattern_gen;

   logic clk;
   logic rst;
   int   tests_run;
   int   tests_failed;
   logic [7:0] prbs_ref [200];

   prbs15_pattern_gen_if #(.DATA_W(8), .REP_W(2)) bus ();

   prbs15_pattern_gen #(
      .DATA_W(8), .NUM_WORDS(4), .REP_W(2), .SEED(15'h7FFF)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Build the reference PRBS word table from the bit recurrence.
   task automatic build_ref();
      bit hist[$];
      for (int i = 0; i < 15; i++) hist.push_back(1'b1);
      for (int w = 0; w < 200; w++) begin
         logic [7:0] word;
         word = 8'h00;
         for (int b = 0; b < 8; b++) begin
            bit nb;
            nb = hist[hist.size() - 15] ^ hist[hist.size() - 14];
            hist.push_back(nb);
            word = {word[6:0], nb};
         end
         prbs_ref[w] = word;
      end
   endtask

   // Start, load with a valid pattern (MSB first), then check stream_len outputs.
   task automatic run_seq(input logic [1:0] n_val, input logic [7:0] w [4],
                          input logic [15:0] pat, input int plen,
                          input int stream_len, input bit do_stop);
      int cap;
      logic [7:0] exp_word;
      logic [7:0] last_word;
      int rep_words;
      cap = 0;
      last_word = 8'h00;
      rep_words = 4 * int'(n_val);
      bus.start = 1'b1;
      bus.n = n_val;
      bus.data_in_valid = 1'b0;
      tick();
      chk("start_phase", 32'(bus.phase), 32'd1);
      chk("start_busy", 32'(bus.busy), 32'd1);
      bus.start = 1'b0;
      bus.n = 2'($urandom);
      for (int i = 0; i < plen; i++) begin
         bus.data_in_valid = pat[plen - 1 - i];
         bus.data_in = bus.data_in_valid ? w[cap] : 8'($urandom);
         tick();
         if (bus.data_in_valid) cap++;
         chk("load_valid", 32'(bus.data_out_valid), 32'd0);
         if (cap < 4) chk("load_phase", 32'(bus.phase), 32'd1);
         else chk("post_load_phase", 32'(bus.phase), (n_val != 2'd0) ? 32'd2 : 32'd3);
      end
      bus.data_in_valid = 1'b0;
      for (int i = 0; i < stream_len; i++) begin
         tick();
         exp_word = (i < rep_words) ? w[i % 4] : prbs_ref[i - rep_words];
         chk("stream_valid", 32'(bus.data_out_valid), 32'd1);
         chk("stream_data", 32'(bus.data_out), 32'(exp_word));
         chk("stream_phase", 32'(bus.phase), (i < rep_words - 1) ? 32'd2 : 32'd3);
         last_word = exp_word;
      end
      if (do_stop) begin
         bus.stop = 1'b1;
         tick();
         bus.stop = 1'b0;
         chk("stop_valid", 32'(bus.data_out_valid), 32'd0);
         chk("stop_phase", 32'(bus.phase), 32'd0);
         chk("stop_busy", 32'(bus.busy), 32'd0);
         if (stream_len > 0) chk("stop_hold", 32'(bus.data_out), 32'(last_word));
      end
   endtask

   initial begin
      logic [7:0] w [4];
      logic [15:0] pat;
      int plen;
      int cnt1;
      logic [1:0] nr;
      tests_run = 0;
      tests_failed = 0;
      build_ref();

      // 1: reset with random inputs
      rst = 1'b0;
      bus.start = 1'($urandom);
      bus.stop = 1'($urandom);
      bus.n = 2'($urandom);
      bus.data_in = 8'($urandom);
      bus.data_in_valid = 1'($urandom);
      tick();
      bus.start = 1'($urandom);
      bus.data_in_valid = 1'($urandom);
      tick();
      chk("rst_data", 32'(bus.data_out), 32'h00);
      chk("rst_valid", 32'(bus.data_out_valid), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_phase", 32'(bus.phase), 32'd0);
      rst = 1'b1;
      bus.start = 1'b0;
      bus.stop = 1'b0;
      tick();
      tick();
      chk("rel_data", 32'(bus.data_out), 32'h00);
      chk("rel_valid", 32'(bus.data_out_valid), 32'd0);
      chk("rel_phase", 32'(bus.phase), 32'd0);

      // 2: n=2 replay then PRBS
      w = '{8'hCC, 8'hDD, 8'hEE, 8'hFF};
      run_seq(2'd2, w, 16'h000F, 4, 10, 1'b1);

      // 3: n=0, straight to PRBS, 100 words
      w = '{8'h11, 8'h22, 8'h33, 8'h44};
      run_seq(2'd0, w, 16'h000F, 4, 100, 1'b1);

      // 4: gapped load
      for (int i = 0; i < 4; i++) w[i] = 8'($urandom);
      nr = 2'($urandom_range(1, 3));
      run_seq(nr, w, 16'b1001101, 7, 4 * int'(nr) + 5, 1'b1);

      // 5: stop after 3rd repeat word, then restart with new words
      for (int i = 0; i < 4; i++) w[i] = 8'($urandom);
      run_seq(2'd2, w, 16'h000F, 4, 3, 1'b1);
      w = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
      run_seq(2'd2, w, 16'h000F, 4, 10, 1'b1);

      // 6: async reset mid-PRBS, between edges
      for (int i = 0; i < 4; i++) w[i] = 8'($urandom);
      run_seq(2'd1, w, 16'h000F, 4, 12, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_data", 32'(bus.data_out), 32'h00);
      chk("arst_valid", 32'(bus.data_out_valid), 32'd0);
      chk("arst_busy", 32'(bus.busy), 32'd0);
      chk("arst_phase", 32'(bus.phase), 32'd0);
      tick();
      rst = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) w[i] = 8'($urandom);
      run_seq(2'd1, w, 16'h000F, 4, 6, 1'b1);
      bus.start = 1'b1;
      bus.stop = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.stop = 1'b0;
      chk("startstop_phase", 32'(bus.phase), 32'd0);
      chk("startstop_busy", 32'(bus.busy), 32'd0);

      // Randomized sequences with random gaps and lengths
      for (int it = 0; it < 6; it++) begin
         for (int i = 0; i < 4; i++) w[i] = 8'($urandom);
         pat = 16'h0000;
         plen = 0;
         cnt1 = 0;
         while (cnt1 < 4) begin
            logic v;
            v = (plen >= 11) ? 1'b1 : 1'($urandom);
            pat = {pat[14:0], v};
            plen++;
            if (v) cnt1++;
         end
         nr = 2'($urandom);
         run_seq(nr, w, pat, plen, 4 * int'(nr) + $urandom_range(3, 20), 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/prbs15_pattern_gen.md
Name: prbs15_pattern_gen

Overview:
Parametrised successor to the fixed 8-bit PRBS-15 pattern block. It captures a user preamble of NUM_WORDS words and replays it n times. It then switches to a continuous PRBS-15 (x^15+x^14+1) stream, DATA_W bits per cycle, until stopped. It sits ahead of the byte sequence detector as the test-pattern source, with a valid qualifier and a phase status for the detector and bench.

Parameters:
DATA_W, 8, word width and PRBS bits produced per cycle (1..15)
NUM_WORDS, 4, preamble depth in words (>=1)
REP_W, 2, width of repeat-count input n
SEED, 15'h7FFF, LFSR load value, non-zero

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
start  input  1  begin a new sequence; honoured only in IDLE
stop  input  1  abort or finish; returns to IDLE
n  input  REP_W  preamble repeat count, sampled at accepted start
data_in  input  DATA_W  preamble word
data_in_valid  input  1  data_in holds a preamble word this cycle
data_out  output  DATA_W  generated word, registered
data_out_valid  output  1  data_out is a valid pattern word
busy  output  1  high in any state other than IDLE
phase  output  2  0=IDLE 1=LOAD 2=REPEAT 3=PRBS

Behaviour:
- Clock and reset: one clock clk; reset rst is asynchronous and active-low.
- Reset (rst=0, async): state IDLE; data_out=0, data_out_valid=0, busy=0, phase=0; LFSR=SEED; word index, repeat counter and preamble buffer cleared to 0.
- IDLE:
  - start=1 and stop=0: latch n, word index 0, go to LOAD.
  - start and stop together: stay IDLE (stop wins).
  - data_out_valid=0, and data_out holds its last value.
- LOAD:
  - Each cycle with data_in_valid=1: buf[idx]<=data_in, idx++. Gaps (valid=0) are allowed and hold idx.
  - On the edge that captures word NUM_WORDS-1: idx<=0; go to REPEAT if latched n!=0, else go to PRBS with LFSR<=SEED.
  - data_out_valid=0 throughout.
- REPEAT:
  - Each cycle: data_out<=buf[idx], data_out_valid<=1, idx wraps modulo NUM_WORDS.
  - Exactly NUM_WORDS*n words are emitted. The repeat counter has width REP_W+clog2(NUM_WORDS)+1.
  - On the edge emitting the last word: go to PRBS with LFSR<=SEED.
  - First valid word appears on the edge after the edge that captured the last preamble word (1-cycle latency).
- PRBS:
  - Each cycle the LFSR s[14:0] advances DATA_W single steps: new=s[14]^s[13]; s<={s[13:0],new}.
  - data_out = the DATA_W new bits; first-generated bit in the MSB. data_out_valid=1.
  - Runs indefinitely. The LFSR period is 32767 and is never all-zero.
- stop=1 in LOAD, REPEAT or PRBS: next edge goes to IDLE with data_out_valid<=0. Partially loaded words are discarded.
- start while busy: ignored.
- A restart always reloads the preamble and reseeds the LFSR, so sequences are reproducible.
- n is sampled only at start. Changes to n mid-sequence have no effect.
- Async reset mid-operation: immediate return to reset values; no partial word is emitted.
- phase and busy are registered state decodes, consistent with state on the same cycle.

Decomposition:
- Package prbs15_pkg holds:
  - the state enum/localparams (IDLE, LOAD, REPEAT, PRBS = 0..3, reused for the phase encoding);
  - POLY_TAP_HI=14 and POLY_TAP_LO=13;
  - LFSR_W=15.
- Sub-module prbs15_step: purely combinational, parametrised by DATA_W. Inputs s_in[14:0]; outputs s_out[14:0] and bits[DATA_W-1:0] after DATA_W steps. The detector/checker reuses it.
- The top holds the FSM, counters, preamble buffer and output registers.

Test Plan:
1. Assert rst=0 for 2 cycles with random inputs -> data_out=00, data_out_valid=0, busy=0, phase=0. Release rst; outputs hold.
2. n=2, start; load CC,DD,EE,FF on consecutive cycles -> starting 1 cycle after FF is captured, 8 valid words CC DD EE FF CC DD EE FF, then PRBS words 00, 02 with valid continuous and phase 2 then 3.
3. n=0, load 11,22,33,44 -> no repeat phase; first valid words 00, 02. Compare 100 words against a reference LFSR model.
4. Load with data_in_valid gaps (pattern 1,0,0,1,1,0,1) -> only the 4 qualified words are captured; replay is exact; valid stays 0 during LOAD.
5. stop pulsed after the 3rd REPEAT word -> valid drops next cycle, phase 0. Restart with new words A1..A4 -> replay shows only the new words; PRBS restarts at 00, 02.
6. Async rst low mid-PRBS, between clock edges -> outputs zero immediately. After release, start with n=1 yields preamble then 00, 02. Also check that start and stop together in IDLE leave phase 0.
